// File: rtl/key_debounce_if.sv
// Key debouncer bus: raw pins and ack in, debounced keys, press pulses
// and interrupt status out. clk/reset stay as plain ports on the block.
interface key_debounce_if #(
  parameter int WIDTH = 8
);
  logic [WIDTH-1:0] key_raw;
  logic             irq_ack;
  logic [WIDTH-1:0] key_stable;
  logic [WIDTH-1:0] key_press;
  logic [WIDTH-1:0] pending;
  logic             irq;

  modport master (output key_raw, irq_ack,
                  input  key_stable, key_press, pending, irq);
  modport slave  (input  key_raw, irq_ack,
                  output key_stable, key_press, pending, irq);
endinterface

// File: rtl/key_debounce.sv
// key_debounce: per-key 2-flop synchronizer + stability counter producing an
// active-low debounced bus, one-cycle press pulses and (when the macro
// KEY_DEBOUNCE_IRQ_EN is defined) a sticky pending register with irq.
// Without KEY_DEBOUNCE_IRQ_EN, pending and irq are tied low and irq_ack
// is ignored.

// One key: synchronizer, counter and stable flop.
module key_debounce_lane #(
  parameter int DEBOUNCE_CYCLES = 250000,
  parameter int CNT_W           = 20
) (
  input  logic clk,
  input  logic reset,
  input  logic raw,
  output logic stable,
  output logic press,
  output logic press_nxt
);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             s1, s2;
  logic [CNT_W-1:0] cnt;
  logic             cnt_done;

  // Accept the change once s2 has differed for DEBOUNCE_CYCLES edges;
  // only a 1->0 acceptance is a press.
  always_comb begin
    cnt_done  = (s2 != stable) && (cnt == CNT_MAX);
    press_nxt = cnt_done & ~s2;
  end

  // Synchronize, count consecutive differing cycles, update stable state.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      s1     <= 1'b1;
      s2     <= 1'b1;
      cnt    <= '0;
      stable <= 1'b1;
      press  <= 1'b0;
    end else begin
      s1    <= raw;
      s2    <= s1;
      press <= press_nxt;
      if (s2 == stable)
        cnt <= '0;
      else if (!cnt_done)
        cnt <= cnt + CNT_W'(1);
      else begin
        stable <= s2;
        cnt    <= '0;
      end
    end
  end
endmodule

module key_debounce #(
  parameter int WIDTH           = 8,
  parameter int DEBOUNCE_CYCLES = 250000,
  parameter int CNT_W           = 20
) (
  input logic           clk,
  input logic           reset,
  key_debounce_if.slave bus
);
  logic [WIDTH-1:0] stable;
  logic [WIDTH-1:0] press;
  logic [WIDTH-1:0] press_nxt;

  for (genvar i = 0; i < WIDTH; i++) begin : g_lane
    key_debounce_lane #(
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
      .CNT_W           (CNT_W)
    ) u_lane (
      .clk       (clk),
      .reset     (reset),
      .raw       (bus.key_raw[i]),
      .stable    (stable[i]),
      .press     (press[i]),
      .press_nxt (press_nxt[i])
    );
  end

  assign bus.key_stable = stable;
  assign bus.key_press  = press;

`ifdef KEY_DEBOUNCE_IRQ_EN
  logic [WIDTH-1:0] pend;

  // Sticky press flags; a same-edge press beats the ack for that bit.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) pend <= '0;
    else        pend <= (pend & ~{WIDTH{bus.irq_ack}}) | press_nxt;
  end

  assign bus.pending = pend;
  assign bus.irq     = |pend;
`else
  logic unused_ack;
  assign unused_ack  = bus.irq_ack;
  assign bus.pending = '0;
  assign bus.irq     = 1'b0;
`endif
endmodule

// File: tb/tb_key_debounce.sv
// Bench for key_debounce with DEBOUNCE_CYCLES=4, CNT_W=3. Table rows carry
// inputs and expected outputs; expectations go through a scoreboard queue.
module tb_key_debounce;
  logic clk = 1'b0;
  logic reset = 1'b0;

  key_debounce_if #(.WIDTH(8)) bus ();

  key_debounce #(.WIDTH(8), .DEBOUNCE_CYCLES(4), .CNT_W(3)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] raw;
    logic       ack;
    logic [7:0] stable;
    logic [7:0] press;
    logic [7:0] pend;   // value in the IRQ build
  } vec_t;

  typedef struct {
    logic [7:0] stable;
    logic [7:0] press;
    logic [7:0] pend;
    int         idx;
  } exp_t;

  vec_t vecs[$];
  exp_t sb[$];
  int   errors = 0;
  int   checks = 0;

  function automatic void add(input logic [7:0] raw, input logic ack,
                              input logic [7:0] st, input logic [7:0] pr,
                              input logic [7:0] pd);
    vec_t v;
    v.raw = raw; v.ack = ack; v.stable = st; v.press = pr; v.pend = pd;
    vecs.push_back(v);
  endfunction

  function automatic logic [7:0] pend_exp(input logic [7:0] p);
`ifdef KEY_DEBOUNCE_IRQ_EN
    return p;
`else
    return 8'h00;
`endif
  endfunction

  task automatic chk(input string name, input int idx,
                     input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s step %0d: got %h expected %h", name, idx, act, exp);
    end
  endtask

  task automatic check_all(input string tag, input int idx,
                           input logic [7:0] st, input logic [7:0] pr,
                           input logic [7:0] pd);
    chk({tag, " key_stable"}, idx, bus.key_stable, st);
    chk({tag, " key_press"},  idx, bus.key_press,  pr);
    chk({tag, " pending"},    idx, bus.pending,    pend_exp(pd));
    chk({tag, " irq"},        idx, {7'd0, bus.irq}, {7'd0, |pend_exp(pd)});
  endtask

  // Drive one row, push its expectation, clock once, pop and compare.
  task automatic step(input string tag, input int idx, input vec_t v);
    exp_t e;
    bus.key_raw = v.raw;
    bus.irq_ack = v.ack;
    e.stable = v.stable; e.press = v.press; e.pend = v.pend; e.idx = idx;
    sb.push_back(e);
    @(posedge clk);
    #1;
    if (sb.size() == 0) begin
      errors++; checks++;
      $display("FAIL scoreboard empty step %0d: got 0 expected 1", idx);
    end else begin
      e = sb.pop_front();
      check_all(tag, e.idx, e.stable, e.press, e.pend);
    end
  endtask

  initial begin
    vec_t v;
    // clean press of key 0
    for (int i = 0; i < 5; i++) add(8'hFE, 0, 8'hFF, 8'h00, 8'h00);
    add(8'hFE, 0, 8'hFE, 8'h01, 8'h01);
    add(8'hFE, 0, 8'hFE, 8'h00, 8'h01);
    add(8'hFE, 0, 8'hFE, 8'h00, 8'h01);
    // key 7 press collides with ack: set wins, bit 0 clears
    for (int i = 0; i < 5; i++) add(8'h7E, 0, 8'hFE, 8'h00, 8'h01);
    add(8'h7E, 1, 8'h7E, 8'h80, 8'h80);
    add(8'h7E, 0, 8'h7E, 8'h00, 8'h80);
    add(8'h7E, 1, 8'h7E, 8'h00, 8'h00);
    // release all: no pulse on 0->1
    for (int i = 0; i < 5; i++) add(8'hFF, 0, 8'h7E, 8'h00, 8'h00);
    add(8'hFF, 0, 8'hFF, 8'h00, 8'h00);
    add(8'hFF, 0, 8'hFF, 8'h00, 8'h00);
    // bounce on key 3: low 3, high 1, then low steadily
    for (int i = 0; i < 3; i++) add(8'hF7, 0, 8'hFF, 8'h00, 8'h00);
    add(8'hFF, 0, 8'hFF, 8'h00, 8'h00);
    for (int i = 0; i < 5; i++) add(8'hF7, 0, 8'hFF, 8'h00, 8'h00);
    add(8'hF7, 0, 8'hF7, 8'h08, 8'h08);
    add(8'hF7, 0, 8'hF7, 8'h00, 8'h08);
    add(8'hF7, 0, 8'hF7, 8'h00, 8'h08);
    add(8'hF7, 1, 8'hF7, 8'h00, 8'h00);
    for (int i = 0; i < 5; i++) add(8'hFF, 0, 8'hF7, 8'h00, 8'h00);
    add(8'hFF, 0, 8'hFF, 8'h00, 8'h00);

    // reset held with all keys low
    bus.key_raw = 8'h00;
    bus.irq_ack = 1'b0;
    reset = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_all("reset", 0, 8'hFF, 8'h00, 8'h00);
    bus.key_raw = 8'hFF;
    reset = 1'b1;
    v.raw = 8'hFF; v.ack = 0; v.stable = 8'hFF; v.press = 8'h00; v.pend = 8'h00;
    step("idle", 0, v);
    step("idle", 1, v);

    for (int i = 0; i < vecs.size(); i++) step("vec", i, vecs[i]);

    // reset in the middle of a count on key 0
    v.raw = 8'hFE; v.ack = 0; v.stable = 8'hFF; v.press = 8'h00; v.pend = 8'h00;
    for (int i = 0; i < 3; i++) step("precount", i, v);
    reset = 1'b0;
    #2;
    check_all("async reset", 0, 8'hFF, 8'h00, 8'h00);
    @(posedge clk);
    #1;
    reset = 1'b1;
    for (int i = 0; i < 5; i++) step("recount", i, v);
    v.stable = 8'hFE; v.press = 8'h01; v.pend = 8'h01;
    step("recount", 5, v);
    v.press = 8'h00;
    step("recount", 6, v);

    if (sb.size() != 0) begin
      errors++; checks++;
      $display("FAIL scoreboard leftover: got %0d expected 0", sb.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
